vector_serializer: RTL and testbench

//  Transmit-side counterpart of the bit-to-vector buffer. Accepts 8-bit vectors from a

---
 rtl/cyic_pkg.sv | 7 +
 rtl/vector_ring_mem.sv | 25 ++
 rtl/vector_serializer.sv | 84 ++++++++
 tb/tb_vector_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cyic_pkg.sv
// Constants and vector type shared by vector_serializer and vector_buffer.
package cyic_pkg;
  localparam int VEC_W     = 8;
  localparam int BIT_IDX_W = 3;

  typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/vector_ring_mem.sv
// Vector ring storage: one synchronous write port, one asynchronous read port.
// No reset on the array; the control logic never reads a slot before it has been written.
module vector_ring_mem
  import cyic_pkg::*;
#(
  parameter int depth = 8,
  localparam int ADDR_W = $clog2(depth)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  vec_t              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output vec_t              rd_data
);

  vec_t mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vector_serializer.sv
// Ring-buffered 8-bit vectors out one bit per bit_req, MSB first; bit valid one cycle after the request.
// Pushes while full are dropped; requests while empty return bit_valid=0. VECTOR_SERIALIZER_LEVEL_EN adds a level port.
module vector_serializer
  import cyic_pkg::*;
#(
  parameter int nb_vectors = 8,
  localparam int PTR_W = $clog2(nb_vectors),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  vec_t             vector_in,
  input  logic             push,
  output logic             full,
  output logic             empty,
  input  logic             bit_req,
  output logic             output_bit,
  output logic             bit_valid
`ifdef VECTOR_SERIALIZER_LEVEL_EN
  ,
  output logic [CNT_W-1:0] level
`endif
);

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [BIT_IDX_W-1:0] bit_idx;
  vec_t                 head_vec;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 last_bit;

  assign full     = (count == CNT_W'(nb_vectors));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = bit_req && !empty;
  assign last_bit = pop_ok && (bit_idx == '1);

  vector_ring_mem #(.depth(nb_vectors)) u_ring (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (vector_in),
    .rd_addr (rd_ptr),
    .rd_data (head_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bit_idx    <= '0;
      output_bit <= 1'b0;
      bit_valid  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;

      if (pop_ok) begin
        // ~bit_idx selects bit 7-bit_idx, giving MSB-first order
        output_bit <= head_vec[~bit_idx];
        bit_valid  <= 1'b1;
        bit_idx    <= bit_idx + 1'b1;
        if (last_bit) rd_ptr <= rd_ptr + 1'b1;
      end else begin
        output_bit <= 1'b0;
        bit_valid  <= 1'b0;
      end

      // The slot is released only once its eighth bit leaves
      case ({push_ok, last_bit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef VECTOR_SERIALIZER_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_vector_serializer.sv
// Scoreboard bench for vector_serializer: the driver predicts bits into a queue, the monitor pops and compares.
module tb_vector_serializer;
  import cyic_pkg::*;

  localparam int NB    = 8;
  localparam int CNT_W = $clog2(NB) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t vector_in = '0;
  logic push = 1'b0;
  logic bit_req = 1'b0;
  logic full, empty, output_bit, bit_valid;
`ifdef VECTOR_SERIALIZER_LEVEL_EN
  logic [CNT_W-1:0] level;
`endif

  always #5 clk = ~clk;

  vector_serializer #(.nb_vectors(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .vector_in  (vector_in),
    .push       (push),
    .full       (full),
    .empty      (empty),
    .bit_req    (bit_req),
    .output_bit (output_bit),
    .bit_valid  (bit_valid)
`ifdef VECTOR_SERIALIZER_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   exp_bits [$];
  vec_t mq [$];
  int   midx = 0;
  vec_t rx [$];
  vec_t part = '0;
  int   part_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every served bit must match the next predicted bit; bytes are reassembled
  always @(negedge clk) begin
    if (bit_valid) begin
      if (exp_bits.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bit: got bit %0b, expected no bit at %0t", output_bit, $time);
      end else begin
        chk("serial_bit", output_bit, exp_bits.pop_front());
      end
      part = {part[6:0], output_bit};
      part_n++;
      if (part_n == 8) begin
        rx.push_back(part);
        part_n = 0;
      end
    end else begin
      chk("idle_bit_zero", output_bit, 0);
    end
    if (rst) part_n = 0;
  end

  // One cycle of stimulus; the model predicts from pre-edge (registered) state
  task automatic step(input logic p, input vec_t v, input logic r, input logic rs);
    bit full_m;
    push = p; vector_in = v; bit_req = r; rst = rs;
    if (rs) begin
      mq.delete();
      midx = 0;
    end else begin
      full_m = (mq.size() == NB);
      if (r && mq.size() != 0) begin
        exp_bits.push_back(mq[0][7-midx]);
        midx++;
        if (midx == 8) begin
          midx = 0;
          void'(mq.pop_front());
        end
      end
      if (p && !full_m) mq.push_back(v);
    end
    @(posedge clk);
    #1;
    chk("full", full, mq.size() == NB);
    chk("empty", empty, mq.size() == 0);
`ifdef VECTOR_SERIALIZER_LEVEL_EN
    chk("level", level, mq.size());
`endif
  endtask

  task automatic rx_chk(input string nm, input vec_t e);
    if (rx.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no byte, expected 0x%0h", nm, e);
    end else begin
      chk(nm, rx.pop_front(), e);
    end
  endtask

  vec_t vecs [200];
  int   sent;
  int   cyc;

  initial begin
    // Reset state
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_output_bit", output_bit, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);

    // 1: A5 -> 1,0,1,0,0,1,0,1
    step(1, 8'hA5, 0, 0);
    chk("t1_not_empty", empty, 0);
    repeat (8) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    rx_chk("t1_byte", 8'hA5);
    chk("t1_empty_after", empty, 1);

    // 2: fill, drop FF, drain in order
    for (int i = 0; i < 8; i++) step(1, vec_t'(i), 0, 0);
    chk("t2_full", full, 1);
    step(1, 8'hFF, 0, 0);
    chk("t2_still_full", full, 1);
    repeat (64) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 8; i++) rx_chk("t2_byte", vec_t'(i));
    chk("t2_no_extra", rx.size(), 0);

    // 3: request while empty
    step(0, '0, 1, 0);
    chk("t3_valid_low", bit_valid, 0);
    chk("t3_bit_low", output_bit, 0);
    chk("t3_empty", empty, 1);

    // 4: push during the final bit of a full ring is rejected, next cycle accepted
    for (int i = 0; i < 8; i++) step(1, vec_t'(8'h10 + i), 0, 0);
    repeat (7) step(0, '0, 1, 0);
    step(1, 8'h3C, 1, 0);
    chk("t4_not_full", full, 0);
    step(1, 8'h3C, 0, 0);
    chk("t4_full_again", full, 1);
    repeat (64) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 8; i++) rx_chk("t4_byte", vec_t'(8'h10 + i));
    rx_chk("t4_last_3c", 8'h3C);
    chk("t4_no_extra", rx.size(), 0);

    // 5: mid-vector reset discards C3
    step(1, 8'hC3, 0, 0);
    repeat (4) step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    chk("t5_empty_after_rst", empty, 1);
    step(1, 8'h81, 0, 0);
    repeat (8) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    rx_chk("t5_byte", 8'h81);
    chk("t5_no_extra", rx.size(), 0);

    // 6: loopback with random gaps on both sides
    for (int i = 0; i < 200; i++) vecs[i] = vec_t'($urandom);
    sent = 0;
    cyc = 0;
    while ((sent < 200 || mq.size() != 0) && cyc < 20000) begin
      logic p;
      logic r;
      p = (sent < 200) && (mq.size() < NB) && ($urandom_range(1, 0) == 1);
      r = ($urandom_range(2, 0) != 0);
      step(p, p ? vecs[sent] : '0, r, 0);
      if (p) sent++;
      cyc++;
    end
    if (cyc >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL t6_timeout: got %0d vectors pushed, expected 200 drained", sent);
    end
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 200; i++) rx_chk("t6_byte", vecs[i]);
    chk("t6_no_extra", rx.size(), 0);
    chk("scoreboard_drained", exp_bits.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
